// File: rtl/axi_r_arbiter_pkg.sv
// Shared types for the two-requester AXI read-channel arbiter.
// Holds the AR/R channel bundles, the AR latch type and the arbiter state encoding.
package axi_r_arbiter_pkg;

    localparam int unsigned AxiAddrW   = 32;
    localparam int unsigned AxiDataW   = 32;
    localparam int unsigned AxiLenW    = 8;
    localparam int unsigned AxiRdPorts = 2;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_ADDR = 2'd1,
        ARB_DATA = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic                arvalid;
        logic [AxiAddrW-1:0] araddr;
        logic [AxiLenW-1:0]  arlen;
        logic [2:0]          arsize;
        logic [1:0]          arburst;
        logic                rready;
    } axi_r_m2s_t;

    typedef struct packed {
        logic                arready;
        logic                rvalid;
        logic [AxiDataW-1:0] rdata;
        logic                rlast;
    } axi_r_s2m_t;

    typedef struct packed {
        logic [AxiAddrW-1:0] araddr;
        logic [AxiLenW-1:0]  arlen;
        logic [2:0]          arsize;
        logic [1:0]          arburst;
    } axi_ar_t;

    function automatic axi_ar_t ar_of(input axi_r_m2s_t m);
        axi_ar_t r;
        r.araddr  = m.araddr;
        r.arlen   = m.arlen;
        r.arsize  = m.arsize;
        r.arburst = m.arburst;
        return r;
    endfunction

    // Replays a latched AR as a request with arvalid set and rready clear.
    function automatic axi_r_m2s_t ar_drive(input axi_ar_t a);
        axi_r_m2s_t m;
        m         = '0;
        m.arvalid = 1'b1;
        m.araddr  = a.araddr;
        m.arlen   = a.arlen;
        m.arsize  = a.arsize;
        m.arburst = a.arburst;
        return m;
    endfunction

endpackage

// File: rtl/axi_r_arbiter_rr.sv
// Two-input grant selector: the port at rr_ptr_i wins when it requests, else the other.
// Tying rr_ptr_i high gives fixed priority to port 1.
module rr_arbiter2 (
    input  logic [1:0] req_i,
    input  logic       rr_ptr_i,
    output logic [1:0] gnt_o,
    output logic       idx_o
);

    always_comb begin
        idx_o = req_i[rr_ptr_i] ? rr_ptr_i : ~rr_ptr_i;
        gnt_o = 2'b00;
        if (req_i != 2'b00) begin
            gnt_o[idx_o] = 1'b1;
        end
    end

endmodule

// File: rtl/axi_r_arbiter.sv
// Shares one AXI read channel between icache (port 0) and dcache/LSU (port 1),
// granting whole transactions from the AR handshake up to the last R beat.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ARB_IDLE | no owner; winner sees arready combinationally
//   ARB_ADDR | replaying the latched AR to the slave until arready
//   ARB_DATA | R beats routed to the owner until the rlast beat
module axi_r_arbiter
    import axi_r_arbiter_pkg::*;
#(
    parameter bit          RoundRobin = 1'b1,
    parameter int unsigned NumPorts   = AxiRdPorts
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  axi_r_m2s_t [NumPorts-1:0] req_i,
    output axi_r_s2m_t [NumPorts-1:0] rsp_o,
    output axi_r_m2s_t                axi_req_o,
    input  axi_r_s2m_t                axi_rsp_i,
    output logic                      busy_o,
    output logic                      owner_o,
    output logic                      len_err_o
);

    arb_state_e         state_q, state_d;
    logic               owner_q, owner_d;
    logic               rr_ptr_q, rr_ptr_d;
    logic               len_err_q, len_err_d;
    logic [AxiLenW-1:0] beat_cnt_q, beat_cnt_d;
    axi_ar_t            ar_q, ar_d;

    logic [1:0] arb_req;
    logic [1:0] arb_gnt;
    logic       arb_idx;
    logic       arb_prio;
    logic       r_beat;

    assign arb_req  = (state_q == ARB_IDLE) ? {req_i[1].arvalid, req_i[0].arvalid} : 2'b00;
    assign arb_prio = RoundRobin ? rr_ptr_q : 1'b1;
    assign r_beat   = (state_q == ARB_DATA) && axi_rsp_i.rvalid && req_i[owner_q].rready;

    rr_arbiter2 u_arb (
        .req_i    (arb_req),
        .rr_ptr_i (arb_prio),
        .gnt_o    (arb_gnt),
        .idx_o    (arb_idx)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ARB_IDLE;
            owner_q    <= 1'b0;
            rr_ptr_q   <= 1'b0;
            len_err_q  <= 1'b0;
            beat_cnt_q <= '0;
            ar_q       <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            len_err_q  <= len_err_d;
            beat_cnt_q <= beat_cnt_d;
            ar_q       <= ar_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        rr_ptr_d   = rr_ptr_q;
        len_err_d  = len_err_q;
        beat_cnt_d = beat_cnt_q;
        ar_d       = ar_q;
        unique case (state_q)
            ARB_IDLE: begin
                if (arb_gnt != 2'b00) begin
                    ar_d       = ar_of(req_i[arb_idx]);
                    owner_d    = arb_idx;
                    beat_cnt_d = '0;
                    state_d    = ARB_ADDR;
                end
            end
            ARB_ADDR: begin
                if (axi_rsp_i.arready) begin
                    state_d = ARB_DATA;
                end
            end
            ARB_DATA: begin
                if (r_beat) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                    if (axi_rsp_i.rlast) begin
                        if (beat_cnt_q != ar_q.arlen) begin
                            len_err_d = 1'b1;
                        end
                        state_d = ARB_IDLE;
                        if (RoundRobin) begin
                            rr_ptr_d = ~owner_q;
                        end
                    end else if (beat_cnt_q == ar_q.arlen) begin
                        // burst overran arlen: flag it but keep routing until rlast
                        len_err_d = 1'b1;
                    end
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_comb begin
        axi_req_o = '0;
        rsp_o     = '0;
        unique case (state_q)
            ARB_IDLE: begin
                rsp_o[0].arready = arb_gnt[0];
                rsp_o[1].arready = arb_gnt[1];
            end
            ARB_ADDR: begin
                axi_req_o = ar_drive(ar_q);
            end
            ARB_DATA: begin
                axi_req_o.rready       = req_i[owner_q].rready;
                rsp_o[owner_q].rvalid = axi_rsp_i.rvalid;
                rsp_o[owner_q].rdata  = axi_rsp_i.rdata;
                rsp_o[owner_q].rlast  = axi_rsp_i.rlast;
            end
            default: ;
        endcase
    end

    assign busy_o    = (state_q != ARB_IDLE);
    assign owner_o   = owner_q;
    assign len_err_o = len_err_q;

endmodule

// File: tb/tb_axi_r_arbiter.sv
// Randomized scoreboard bench for axi_r_arbiter: requesters and a slave model drive
// stimulus and queue expectations; a negedge monitor checks against a transaction model.
module tb_axi_r_arbiter;
    import axi_r_arbiter_pkg::*;

    typedef struct packed {
        logic [31:0] d;
        logic        l;
    } beat_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    axi_r_m2s_t [1:0] rq;
    axi_r_s2m_t [1:0] rsp;
    axi_r_m2s_t       axi_req;
    axi_r_s2m_t       sl;
    logic             busy, owner, len_err;

    axi_r_m2s_t [1:0] fp_rq;
    axi_r_s2m_t [1:0] fp_rsp;
    axi_r_m2s_t       fp_axi_req;
    axi_r_s2m_t       fp_sl;
    logic             fp_busy, fp_owner, fp_len_err;

    axi_r_arbiter #(.RoundRobin(1'b1), .NumPorts(2)) dut (
        .clk_i(clk), .rst_ni(rst_n), .req_i(rq), .rsp_o(rsp),
        .axi_req_o(axi_req), .axi_rsp_i(sl),
        .busy_o(busy), .owner_o(owner), .len_err_o(len_err)
    );

    axi_r_arbiter #(.RoundRobin(1'b0), .NumPorts(2)) dut_fp (
        .clk_i(clk), .rst_ni(rst_n), .req_i(fp_rq), .rsp_o(fp_rsp),
        .axi_req_o(fp_axi_req), .axi_rsp_i(fp_sl),
        .busy_o(fp_busy), .owner_o(fp_owner), .len_err_o(fp_len_err)
    );

    int      n_vec = 0;
    int      n_err = 0;
    axi_ar_t exp_ar_q[2][$];
    beat_t   exp_r_q[$];

    // stimulus state
    int      gap[2];
    bit [1:0] en;
    bit [1:0] fixv;
    axi_ar_t fix_ar;
    int      force_ard, adj;
    int      s_st, s_d, s_left, s_sent, s_done;

    // reference model state (monitor only)
    int       m_state = 0;
    logic     m_rr = 1'b0, m_own = 1'b0, m_len_err = 1'b0;
    logic [7:0] m_beat = 8'd0;
    axi_ar_t  m_ar;
    int       m_wd = 0;
    int       fp_state = 0;
    logic     fp_own = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic axi_ar_t rand_ar();
        axi_ar_t a;
        a.araddr  = $urandom;
        a.arlen   = 8'($urandom_range(0, 7));
        a.arsize  = 3'($urandom_range(0, 3));
        a.arburst = 2'($urandom_range(0, 2));
        return a;
    endfunction

    always @(negedge clk) begin
        axi_r_m2s_t e;
        axi_r_s2m_t t;
        beat_t      b;
        logic [1:0] v, eg, fv, feg;
        logic       w;
        if (!rst_n) begin
            chk("rst_axi_req", 64'(axi_req), 64'd0);
            chk("rst_rsp0", 64'(rsp[0]), 64'd0);
            chk("rst_rsp1", 64'(rsp[1]), 64'd0);
            chk("rst_busy", 64'(busy), 64'd0);
            chk("rst_owner", 64'(owner), 64'd0);
            chk("rst_len_err", 64'(len_err), 64'd0);
            m_state = 0; m_rr = 1'b0; m_own = 1'b0; m_len_err = 1'b0; m_wd = 0;
            fp_state = 0;
            exp_ar_q[0].delete(); exp_ar_q[1].delete(); exp_r_q.delete();
        end else begin
            v  = {rq[1].arvalid, rq[0].arvalid};
            eg = 2'b00;
            w  = 1'b0;
            if (m_state == 0 && v != 2'b00) begin
                w = (v == 2'b11) ? m_rr : v[1];
                eg[w] = 1'b1;
            end
            chk("grant", 64'({rsp[1].arready, rsp[0].arready}), 64'(eg));
            chk("busy", 64'(busy), 64'(m_state != 0));
            chk("owner", 64'(owner), 64'(m_own));
            chk("len_err", 64'(len_err), 64'(m_len_err));
            case (m_state)
                0: begin
                    chk("idle_axi_req", 64'(axi_req), 64'd0);
                    for (int p = 0; p < 2; p++) begin
                        t = '0; t.arready = eg[p];
                        chk("idle_rsp", 64'(rsp[p]), 64'(t));
                    end
                    if (eg != 2'b00) begin
                        chk("grant_has_req", 64'(exp_ar_q[w].size() != 0), 64'd1);
                        if (exp_ar_q[w].size() != 0) m_ar = exp_ar_q[w].pop_front();
                        m_own = w; m_beat = 8'd0; m_state = 1;
                    end
                end
                1: begin
                    e = '0; e.arvalid = 1'b1; e.araddr = m_ar.araddr; e.arlen = m_ar.arlen;
                    e.arsize = m_ar.arsize; e.arburst = m_ar.arburst;
                    chk("addr_axi_req", 64'(axi_req), 64'(e));
                    chk("addr_rsp0", 64'(rsp[0]), 64'd0);
                    chk("addr_rsp1", 64'(rsp[1]), 64'd0);
                    if (sl.arready) m_state = 2;
                end
                default: begin
                    chk("data_arvalid", 64'(axi_req.arvalid), 64'd0);
                    chk("data_rready", 64'(axi_req.rready), 64'(rq[m_own].rready));
                    t = '0; t.rvalid = sl.rvalid; t.rdata = sl.rdata; t.rlast = sl.rlast;
                    chk("data_owner_rsp", 64'(rsp[m_own]), 64'(t));
                    chk("data_other_rsp", 64'(rsp[~m_own]), 64'd0);
                    if (sl.rvalid && rq[m_own].rready) begin
                        chk("beat_expected", 64'(exp_r_q.size() != 0), 64'd1);
                        if (exp_r_q.size() != 0) begin
                            b = exp_r_q.pop_front();
                            chk("beat_data", 64'({rsp[m_own].rdata, rsp[m_own].rlast}), 64'(b));
                        end
                        if (sl.rlast) begin
                            if (m_beat != m_ar.arlen) m_len_err = 1'b1;
                            m_state = 0;
                            m_rr = ~m_own;
                        end else if (m_beat == m_ar.arlen) begin
                            m_len_err = 1'b1;
                        end
                        m_beat = m_beat + 8'd1;
                    end
                end
            endcase
            m_wd = (m_state != 0) ? m_wd + 1 : 0;
            if (m_wd > 400) begin
                chk("watchdog", 64'd1, 64'd0);
                m_state = 0; m_wd = 0;
            end

            fv  = {fp_rq[1].arvalid, fp_rq[0].arvalid};
            feg = 2'b00;
            if (fp_state == 0 && fv != 2'b00) feg = fv[1] ? 2'b10 : 2'b01;
            chk("fp_grant", 64'({fp_rsp[1].arready, fp_rsp[0].arready}), 64'(feg));
            chk("fp_busy", 64'(fp_busy), 64'(fp_state != 0));
            case (fp_state)
                0: if (fv != 2'b00) begin fp_state = 1; fp_own = fv[1]; end
                1: if (fp_sl.arready) fp_state = 2;
                default: if (fp_sl.rvalid && fp_rq[fp_own].rready && fp_sl.rlast) fp_state = 0;
            endcase
        end
    end

    task automatic step();
        bit         hs[2];
        bit         ar_hs, b_hs, arv_seen;
        logic [7:0] len_seen;
        axi_ar_t    a;
        @(negedge clk);
        for (int p = 0; p < 2; p++) hs[p] = rq[p].arvalid && rsp[p].arready;
        ar_hs    = axi_req.arvalid && sl.arready;
        b_hs     = sl.rvalid && axi_req.rready;
        arv_seen = axi_req.arvalid;
        len_seen = axi_req.arlen;
        @(posedge clk);
        #1;
        for (int p = 0; p < 2; p++) begin
            if (rq[p].arvalid) begin
                if (hs[p]) begin
                    rq[p].arvalid = 1'b0;
                    gap[p] = $urandom_range(0, 3);
                end
            end else if (gap[p] > 0) begin
                gap[p]--;
            end else if (en[p]) begin
                if (fixv[p]) begin a = fix_ar; fixv[p] = 1'b0; end
                else a = rand_ar();
                rq[p].araddr = a.araddr; rq[p].arlen = a.arlen;
                rq[p].arsize = a.arsize; rq[p].arburst = a.arburst;
                rq[p].arvalid = 1'b1;
                exp_ar_q[p].push_back(a);
            end
            rq[p].rready = ($urandom_range(0, 3) != 0);
        end
        if (s_st == 0 && arv_seen) begin
            s_d = (force_ard >= 0) ? force_ard : $urandom_range(0, 3);
            force_ard = -1;
            s_st = 1;
        end else if (s_st == 1) begin
            if (ar_hs) begin
                sl.arready = 1'b0;
                s_left = int'(len_seen) + 1 + adj;
                s_sent = 0;
                s_st = 2;
            end else if (s_d > 0) begin
                s_d--;
            end
        end else if (s_st == 2) begin
            if (b_hs) begin
                if (sl.rlast) begin
                    sl = '0; s_st = 0; s_done++;
                end else begin
                    sl.rvalid = 1'b0;
                end
            end
            if (s_st == 2 && !sl.rvalid && $urandom_range(0, 3) != 0) begin
                s_sent++;
                sl.rvalid = 1'b1;
                sl.rdata  = $urandom;
                sl.rlast  = (s_sent == s_left);
                exp_r_q.push_back({sl.rdata, sl.rlast});
            end
        end
        if (s_st == 1 && s_d == 0) sl.arready = 1'b1;
    endtask

    task automatic drain();
        en = 2'b00;
        for (int i = 0; i < 400; i++) begin
            if (!rq[0].arvalid && !rq[1].arvalid && s_st == 0) break;
            step();
        end
        step();
        step();
    endtask

    task automatic one_txn(input int p, input axi_ar_t a, input int ard, input int ad);
        int d0;
        d0 = s_done;
        gap[p] = 0; fix_ar = a; fixv[p] = 1'b1; force_ard = ard; adj = ad;
        en[p] = 1'b1;
        step();
        en = 2'b00;
        for (int i = 0; i < 300 && s_done == d0; i++) step();
        adj = 0;
        drain();
    endtask

    initial begin
        rq = '0; sl = '0; fp_rq = '0; fp_sl = '0;
        gap[0] = 0; gap[1] = 0; en = 2'b00; fixv = 2'b00; fix_ar = '0;
        force_ard = -1; adj = 0; s_st = 0; s_d = 0; s_left = 0; s_sent = 0; s_done = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        fp_rq[0].arvalid = 1'b1; fp_rq[0].rready = 1'b1; fp_rq[0].araddr = 32'h0000_1000;
        fp_rq[1].arvalid = 1'b1; fp_rq[1].rready = 1'b1; fp_rq[1].araddr = 32'h0000_2000;
        fp_sl.arready = 1'b1; fp_sl.rvalid = 1'b1; fp_sl.rdata = 32'hA5A5_0000; fp_sl.rlast = 1'b1;

        one_txn(0, axi_ar_t'{araddr: 32'h8000_0000, arlen: 8'd7, arsize: 3'd2, arburst: 2'd1}, 5, 0);

        en = 2'b11;
        for (int i = 0; i < 1500; i++) step();
        drain();

        @(posedge clk);
        #1 fp_rq[1].arvalid = 1'b0;

        one_txn(0, axi_ar_t'{araddr: 32'h0000_4000, arlen: 8'd3, arsize: 3'd2, arburst: 2'd1}, 0, -2);
        for (int i = 0; i < 5; i++) step();

        gap[0] = 0; fix_ar = axi_ar_t'{araddr: 32'h0000_8000, arlen: 8'd7, arsize: 3'd3, arburst: 2'd1};
        fixv[0] = 1'b1; force_ard = 1; en = 2'b01;
        step();
        en = 2'b00;
        for (int i = 0; i < 200 && !(s_st == 2 && s_sent >= 3); i++) step();
        #1 rst_n = 1'b0;
        rq = '0; sl = '0; s_st = 0; s_sent = 0; fixv = 2'b00; force_ard = -1;
        gap[0] = 0; gap[1] = 0;
        exp_ar_q[0].delete(); exp_ar_q[1].delete(); exp_r_q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        one_txn(1, rand_ar(), -1, 0);
        for (int k = 0; k < 3; k++) begin
            gap[0] = 0; gap[1] = 0; en = 2'b11;
            step();
            en = 2'b00;
            drain();
        end

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/axi_r_arbiter.md
Name: axi_r_arbiter

Overview:
- Shares the core's single AXI read channel between two requesters: port 0 (icache line refill, burst) and port 1 (dcache refill / LSU uncached load).
- Grants one whole read transaction at a time and holds the grant from the AR handshake until the last R beat.
- Latches the winning AR request, replays it to the slave, and routes R beats back only to the owner.
- Sits between the cache/LSU read masters and the top-level AXI master port.

Parameters:
- RoundRobin, 1: 1 = alternate priority after each completed transaction; 0 = fixed priority, port 1 (data side) wins.
- NumPorts, 2: number of requesters; fixed at 2 in this revision.

Ports:
- clk_i  input  1  core clock
- rst_ni  input  1  asynchronous active-low reset
- req_i  input  axi_r_m2s_t[1:0]  per-requester AR/R master signals (index 0 icache, 1 dcache)
- rsp_o  output  axi_r_s2m_t[1:0]  per-requester arready/rvalid/rdata/rlast
- axi_req_o  output  axi_r_m2s_t  to the shared AXI slave
- axi_rsp_i  input  axi_r_s2m_t  from the shared AXI slave
- busy_o  output  1  a transaction is owned (state != IDLE)
- owner_o  output  1  index of the current or last owner
- len_err_o  output  1  sticky flag: rlast did not coincide with beat arlen

Behaviour:
- Clocking and reset: one clock, clk_i. Reset is asynchronous, active-low, on rst_ni.
- Reset values:
  - state = IDLE; owner = 0; rr_ptr = 0 (port 0 has priority first); beat_cnt = 0; len_err = 0.
  - All of axi_req_o is 0. All of rsp_o is 0.
- IDLE state:
  - Winner selection: RoundRobin=1 picks the port at rr_ptr if its arvalid is high, otherwise the other port. RoundRobin=0 picks port 1 over port 0.
  - The winner sees rsp_o[w].arready=1 combinationally in the same cycle. The loser sees arready=0.
  - On that edge: latch araddr/arlen/arsize/arburst; set owner = w; clear beat_cnt; move to ADDR.
  - No requests: stay in IDLE; all outputs 0.
- ADDR state:
  - axi_req_o.arvalid = 1, carrying the latched fields. Fields stay stable while arvalid=1 and arready=0.
  - On axi_rsp_i.arready=1: move to DATA.
  - rsp_o arready = 0 for both ports.
- DATA state:
  - rsp_o[owner].rvalid/rdata/rlast = axi_rsp_i fields. axi_req_o.rready = req_i[owner].rready.
  - The non-owner sees rvalid=0 and rdata=0.
  - Each beat (rvalid && rready) increments beat_cnt, 8-bit, wrapping.
  - Beat with rlast=1: return to IDLE. If RoundRobin=1, rr_ptr = ~owner.
  - Length check, raising len_err:
    - rlast=1 with beat_cnt != latched arlen;
    - or beat_cnt == arlen without rlast, in which case the state remains DATA until rlast.
  - len_err clears only on reset.
- Latency: AR reaches the slave 1 cycle after the requester's AR handshake. R path is combinational passthrough (0 cycles).
- Back-to-back transactions: a new grant can occur on the cycle after the last beat, so at least 1 idle cycle between transactions.
- Simultaneous requests in IDLE: exactly one grant. The loser's arvalid stays asserted (AXI rule) and it is served next.
- Requester drops arvalid after grant: no effect; the transaction completes from the latched copy.
- Reset asserted mid-ADDR or mid-DATA: immediate return to IDLE with outputs 0. The outstanding slave transaction is the system reset's concern.
- busy_o = (state != IDLE). owner_o = owner register.

Decomposition:
- Shared package gains:
  - arb_state_e {ARB_IDLE, ARB_ADDR, ARB_DATA};
  - localparam AxiRdPorts = 2;
  - typedef axi_ar_t (araddr, arlen, arsize, arburst) for the latch.
- Existing types used: axi_r_m2s_t/axi_r_s2m_t.
- One natural sub-module: rr_arbiter2, a 2-input priority/round-robin grant selector (pure combinational plus rr_ptr input).

Test Plan:
- Port 0 only, araddr=0x8000_0000, arlen=7: rsp_o[0].arready pulses 1 cycle; axi arvalid next cycle with same fields; 8 beats routed to port 0; IDLE after rlast; len_err_o=0.
- Both ports request in the same cycle, RoundRobin=1 after reset: port 0 granted first, then port 1; next simultaneous pair grants port 0 again (alternation).
- RoundRobin=0, both requesting continuously: port 1 always granted; port 0 only when port 1 is idle.
- Slave holds arready=0 for 5 cycles: axi arvalid stays 1 with fields unchanged; no R routing until DATA; rsp_o[1].rvalid stays 0 throughout port 0's transaction.
- arlen=3 but slave asserts rlast on beat 2: len_err_o=1 from the next cycle, sticky; state returns to IDLE.
- rst_ni low during beat 3 of an 8-beat burst: state IDLE, all outputs 0 asynchronously; after release, a new port 1 request is granted normally.
